ecc_secded_dec_pipe: RTL
========================

# ecc_secded_dec_pipe

Parametrised, pipelined SEC-DED (Hsiao-style) decoder for the SRAM read path. It accepts a codeword from SRAM read data through a valid/ready handshake and computes the syndrome. It then corrects single-bit errors (or only reports them, in detect-only mode) and returns data, error flags and a transaction tag two stages later. It also keeps saturating error counters and a first-uncorrectable-error log for software.

## Interface
Parameters:
- DATA_W, 32, data bits per word; 32 and 64 supported.
- CHK_W, 7, check bits; 7 for DATA_W=32, 8 for DATA_W=64.
- TAG_W, 8, width of opaque tag carried alongside each word.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder can accept.
- in_cw  in  DATA_W+CHK_W  codeword; [DATA_W-1:0] data, [DATA_W+CHK_W-1:DATA_W] check.
- in_tag  in  TAG_W  tag, returned unchanged.
- correct_en  in  1  1 = correct single errors; 0 = detect-only, raw data out. Sampled with each accepted word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected (or raw) data.
- out_tag  out  TAG_W  tag of this word.
- out_syn  out  CHK_W  syndrome of this word.
- out_ce  out  1  single-bit error found (corrected if correct_en was 1).
- out_ue  out  1  uncorrectable error.
- cnt_clr  in  1  clear counters and log.
- ce_cnt  out  CNT_W  correctable errors delivered.
- ue_cnt  out  CNT_W  uncorrectable errors delivered.
- ue_log_valid  out  1  log holds an entry.
- ue_log_syn  out  CHK_W  syndrome of first logged UE.
- ue_log_tag  out  TAG_W  tag of first logged UE.

## Operation
- H-matrix columns:
  - Check bit j uses the one-hot column 1<<j.
  - Data bit i uses the i-th CHK_W-bit value of odd weight ≥3, in ascending numeric order. For CHK_W=7, bits 0..4 are 07,0B,0D,0E,13 (hex).
  - The matching encoder uses the same rule.
- Syndrome: XOR of the columns of all codeword bits equal to 1.
- Classification:
  - syn==0 → clean.
  - syn odd weight and equal to some column → CE at that bit.
  - Any other nonzero syndrome → UE; this covers even weight and odd weight with no matching column.
- Correction:
  - CE on a data bit with correct_en=1 → that bit is flipped in out_data.
  - CE on a check bit → data unchanged, out_ce=1.
  - UE or correct_en=0 → raw data, flags still valid.
- out_ce and out_ue are mutually exclusive.
- Stage 1 registers the codeword, tag, correct_en and syndrome. Stage 2 registers the corrected data and flags.
- Each stage loads when it is empty or its contents advance in the same cycle. in_ready = !s1_valid || s1 advancing; s1 advances when !s2_valid || out_ready.
- Counters and log update only on an output transfer (out_valid && out_ready):
  - out_ce → ce_cnt+1, saturating at all-ones.
  - out_ue → ue_cnt+1, saturating.
  - If ue_log_valid==0 on a UE → capture syndrome and tag, set ue_log_valid.
- cnt_clr in a cycle with no event → counters 0, log cleared.
  - cnt_clr in the same cycle as a CE transfer → ce_cnt=1.
  - cnt_clr in the same cycle as a UE transfer → ue_cnt=1 and the log captures that UE.

## Timing
- Latency: word accepted at edge N → out_valid high after edge N+2, when unstalled.
- Throughput: one word per cycle with out_ready held high.
- Backpressure:
  - out_valid, out_data, out_tag, out_syn, out_ce and out_ue hold stable while out_valid && !out_ready.
  - in_ready falls in the cycle both stages are full and out_ready=0.
- Reset, synchronous:
  - Both stage valids are 0.
  - out_valid, out_data, out_tag, out_syn, out_ce, out_ue, ce_cnt, ue_cnt, ue_log_valid, ue_log_syn and ue_log_tag are all 0.
  - in_ready is 1 from the first cycle after reset.
- rst mid-flight drops in-flight words; nothing is counted for them.
- All outputs are registered except in_ready, which is combinational from out_ready.

## Test plan
- Clean word: in_cw = {7'h07, 32'h0000_0001}, tag 8'h11 → two cycles later out_data 32'h0000_0001, out_syn 0, ce=ue=0, out_tag 8'h11.
- Single data error: all-zero codeword with data bit 0 flipped, correct_en=1 → out_data 0, out_syn 7'h07, out_ce=1, ce_cnt=1. Repeat with correct_en=0 → out_data 32'h0000_0001, out_ce=1.
- Double error: data bits 0,1 flipped, tag 8'hA5 → out_syn 7'h0C, out_ue=1, ue_cnt=1, ue_log_syn 7'h0C, ue_log_tag 8'hA5. A second UE with tag 8'h5A leaves the log at 8'hA5.
- Backpressure: stream 4 words with tags 0..3, hold out_ready=0 for 5 cycles.
  - in_ready must be 0 after two words are accepted.
  - Outputs stay stable while stalled.
  - Tags emerge in order 0..3, none lost or duplicated, each counted once.
- Saturation and clear:
  - With CNT_W=2, send 5 CE words → ce_cnt=3.
  - Assert cnt_clr together with a CE transfer → ce_cnt=1.
- Reset mid-flight: assert rst with both stages full → next cycle out_valid=0, counters 0, in_ready=1.

Source files
------------

// File: rtl/ecc_secded_dec_pipe.sv
// Pipelined Hsiao SEC-DED decoder for SRAM read data, with saturating error counters and a first-UE log.
// Latency: 2 cycles from input handshake to out_valid; sustains one word per cycle when unstalled.
// Backpressure: both stages hold while out_ready=0; in_ready drops once both stages are full and stalled.
module ecc_secded_dec_pipe #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int TAG_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W+CHK_W-1:0] in_cw,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic                    correct_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [TAG_W-1:0]        out_tag,
   output logic [CHK_W-1:0]        out_syn,
   output logic                    out_ce,
   output logic                    out_ue,
   input  logic                    cnt_clr,
   output logic [CNT_W-1:0]        ce_cnt,
   output logic [CNT_W-1:0]        ue_cnt,
   output logic                    ue_log_valid,
   output logic [CHK_W-1:0]        ue_log_syn,
   output logic [TAG_W-1:0]        ue_log_tag
);

   // H-matrix data columns: the i-th odd-weight (>=3) CHK_W-bit value in ascending order.
   // Check bit j uses the one-hot column 1<<j, so it needs no table entry.
   typedef logic [DATA_W-1:0][CHK_W-1:0] col_tbl_t;

   function automatic col_tbl_t gen_data_cols();
      col_tbl_t tbl;
      int       idx;
      int       w;
      tbl = '0;
      idx = 0;
      for (int v = 0; v < (1 << CHK_W); v++) begin
         w = $countones(v);
         if ((w % 2 == 1) && (w >= 3) && (idx < DATA_W)) begin
            tbl[idx] = CHK_W'(v);
            idx++;
         end
      end
      return tbl;
   endfunction

   localparam col_tbl_t DATA_COL = gen_data_cols();

   // Stage payloads. Stage 1 keeps only the data half of the codeword: the
   // check bits are fully summarised by the syndrome computed on entry.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic [CHK_W-1:0]  syn;
      logic              en;
   } s1_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic [CHK_W-1:0]  syn;
      logic              ce;
      logic              ue;
   } s2_t;

   logic              s1_vld_q, s1_vld_d;
   s1_t               s1_q, s1_d;
   logic              s2_vld_q, s2_vld_d;
   s2_t               s2_q, s2_d;

   logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
   logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;
   logic              log_vld_q, log_vld_d;
   logic [CHK_W-1:0]  log_syn_q, log_syn_d;
   logic [TAG_W-1:0]  log_tag_q, log_tag_d;

   logic              s1_adv;
   logic              in_fire;
   logic              out_fire;
   logic [CHK_W-1:0]  syn_in;
   logic [DATA_W-1:0] flip;
   logic              hit_chk;
   logic              dec_ce;
   logic              dec_ue;
   logic [DATA_W-1:0] dec_data;
   logic [CNT_W-1:0]  ce_base;
   logic [CNT_W-1:0]  ue_base;

   // Handshake: stage 1 may move on whenever stage 2 is empty or draining this cycle.
   assign s1_adv   = !s2_vld_q || out_ready;
   assign in_ready = !s1_vld_q || s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_vld_q && out_ready;

   // Syndrome of the incoming codeword: check bits enter directly, data bits via their columns.
   always_comb begin
      syn_in = in_cw[DATA_W+CHK_W-1:DATA_W];
      for (int i = 0; i < DATA_W; i++) begin
         if (in_cw[i]) begin
            syn_in = syn_in ^ DATA_COL[i];
         end
      end
   end

   // Stage 1 next state: load on accept, empty when drained with nothing new arriving.
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_d     = s1_q;
      if (in_ready) begin
         s1_vld_d = in_valid;
      end
      if (in_fire) begin
         s1_d.data = in_cw[DATA_W-1:0];
         s1_d.tag  = in_tag;
         s1_d.syn  = syn_in;
         s1_d.en   = correct_en;
      end
   end

   // Classify the stage-1 syndrome and build the corrected data word.
   // Columns are all distinct, so at most one flip bit can be set.
   always_comb begin
      flip = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (s1_q.syn == DATA_COL[i]) begin
            flip[i] = 1'b1;
         end
      end
      hit_chk  = $onehot(s1_q.syn);
      dec_ce   = (|flip) || hit_chk;
      dec_ue   = (s1_q.syn != '0) && !dec_ce;
      dec_data = s1_q.en ? (s1_q.data ^ flip) : s1_q.data;
   end

   // Stage 2 next state: take the decoded word when stage 1 advances, otherwise hold.
   always_comb begin
      s2_vld_d = s2_vld_q;
      s2_d     = s2_q;
      if (s1_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_d.data = dec_data;
            s2_d.tag  = s1_q.tag;
            s2_d.syn  = s1_q.syn;
            s2_d.ce   = dec_ce;
            s2_d.ue   = dec_ue;
         end
      end
   end

   // Counters and UE log: clear first, then apply this cycle's delivered word on top.
   always_comb begin
      ce_base   = cnt_clr ? '0 : ce_cnt_q;
      ue_base   = cnt_clr ? '0 : ue_cnt_q;
      ce_cnt_d  = ce_base;
      ue_cnt_d  = ue_base;
      log_vld_d = cnt_clr ? 1'b0 : log_vld_q;
      log_syn_d = cnt_clr ? '0 : log_syn_q;
      log_tag_d = cnt_clr ? '0 : log_tag_q;
      if (out_fire && s2_q.ce && (ce_base != '1)) begin
         ce_cnt_d = ce_base + CNT_W'(1);
      end
      if (out_fire && s2_q.ue && (ue_base != '1)) begin
         ue_cnt_d = ue_base + CNT_W'(1);
      end
      if (out_fire && s2_q.ue && !log_vld_d) begin
         log_vld_d = 1'b1;
         log_syn_d = s2_q.syn;
         log_tag_d = s2_q.tag;
      end
   end

   // Pipeline registers; reset drops any in-flight words.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_q     <= '0;
         s2_vld_q <= 1'b0;
         s2_q     <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_q     <= s1_d;
         s2_vld_q <= s2_vld_d;
         s2_q     <= s2_d;
      end
   end

   // Error counter and log registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_cnt_q  <= '0;
         ue_cnt_q  <= '0;
         log_vld_q <= 1'b0;
         log_syn_q <= '0;
         log_tag_q <= '0;
      end else begin
         ce_cnt_q  <= ce_cnt_d;
         ue_cnt_q  <= ue_cnt_d;
         log_vld_q <= log_vld_d;
         log_syn_q <= log_syn_d;
         log_tag_q <= log_tag_d;
      end
   end

   assign out_valid    = s2_vld_q;
   assign out_data     = s2_q.data;
   assign out_tag      = s2_q.tag;
   assign out_syn      = s2_q.syn;
   assign out_ce       = s2_q.ce;
   assign out_ue       = s2_q.ue;
   assign ce_cnt       = ce_cnt_q;
   assign ue_cnt       = ue_cnt_q;
   assign ue_log_valid = log_vld_q;
   assign ue_log_syn   = log_syn_q;
   assign ue_log_tag   = log_tag_q;

endmodule
